// File: rtl/alu_exec_pkg.sv
// Shared constants for the nibble-processor execute stage: opcodes, FSM states
// and the default datapath width.
package alu_exec_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_NAND = 3'b011,
    OP_CMP  = 3'b100,
    OP_MUL  = 3'b101,
    OP_ADC  = 3'b110,
    OP_NOP  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_stage_mul.sv
// Unsigned shift-add multiplier: load latches the operands, each step adds one
// partial product; done flags the step whose prod_next is the final product.
module mul_shift_add
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    done      = step && (cnt_q == CW'(WIDTH - 1));
    if (load) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step) begin
      prod_d   = prod_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: combines the accumulator with a bus operand, owns the carry and
// zero flags and pulses acc_en once per committed result.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             acc_en,
  output logic             busy,
  output logic             carry,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               acc_en_q, acc_en_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic               mul_load, mul_step, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum_add, sum_adc, diff;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .a         (acc_in),
    .b         (operand),
    .prod_next (mul_prod),
    .done      (mul_done)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_en_d = 1'b0;
    carry_d  = carry_q;
    zero_d   = zero_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    sum_add  = {1'b0, acc_in} + {1'b0, operand};
    sum_adc  = sum_add + {{WIDTH{1'b0}}, carry_q};
    // The borrow out of the extended subtraction is the inverse of A>=B.
    diff     = {1'b0, acc_in} - {1'b0, operand};

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (op_e'(op))
            OP_PASS: begin
              result_d = operand;
              zero_d   = (operand == '0);
              acc_en_d = 1'b1;
            end
            OP_ADD: begin
              {carry_d, result_d} = sum_add;
              zero_d   = (sum_add[WIDTH-1:0] == '0);
              acc_en_d = 1'b1;
            end
            OP_SUB: begin
              result_d = diff[WIDTH-1:0];
              carry_d  = ~diff[WIDTH];
              zero_d   = (diff[WIDTH-1:0] == '0);
              acc_en_d = 1'b1;
            end
            OP_NAND: begin
              result_d = ~(acc_in & operand);
              carry_d  = 1'b0;
              zero_d   = ((acc_in & operand) == '1);
              acc_en_d = 1'b1;
            end
            OP_CMP: begin
              carry_d = ~diff[WIDTH];
              zero_d  = (diff[WIDTH-1:0] == '0);
            end
            OP_MUL: begin
              mul_load = 1'b1;
              state_d  = ST_MUL;
            end
            OP_ADC: begin
              {carry_d, result_d} = sum_adc;
              zero_d   = (sum_adc[WIDTH-1:0] == '0);
              acc_en_d = 1'b1;
            end
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
          zero_d   = (mul_prod[WIDTH-1:0] == '0);
          acc_en_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      acc_en_q <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_en_q <= acc_en_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign acc_en = acc_en_q;
  assign busy   = (state_q == ST_MUL);
  assign carry  = carry_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios with literal
// expectations plus randomized traffic, all compared against a behavioural model.
module tb_alu_exec_stage;

  localparam int W = 4;
  localparam logic [2:0] PASS = 3'b000, ADD = 3'b001, SUB = 3'b010, NAND = 3'b011,
                         CMP = 3'b100, MUL = 3'b101, ADC = 3'b110, NOP = 3'b111;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] acc_drv, operand, acc_in, acc_q;
  logic         use_acc;
  logic [W-1:0] result;
  logic         acc_en, busy, carry, zero;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state: committed outputs plus a MUL countdown.
  logic [W-1:0]   m_result;
  logic           m_carry, m_zero, m_acc_en, m_busy;
  int             mul_left;
  logic [2*W-1:0] mul_prod;

  always #5 clk = ~clk;

  assign acc_in = use_acc ? acc_q : acc_drv;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .acc_in  (acc_in),
    .operand (operand),
    .result  (result),
    .acc_en  (acc_en),
    .busy    (busy),
    .carry   (carry),
    .zero    (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_result = '0; m_carry = 1'b0; m_zero = 1'b0; m_acc_en = 1'b0;
      mul_left = 0;
      acc_q <= '0;
    end else begin
      m_acc_en = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          m_result = mul_prod[W-1:0];
          m_carry  = (mul_prod[2*W-1:W] != 0);
          m_zero   = (m_result == 0);
          m_acc_en = 1'b1;
        end
      end else if (start) begin
        case (op)
          PASS: begin m_result = operand; m_acc_en = 1'b1; end
          ADD:  begin {m_carry, m_result} = {1'b0, acc_in} + {1'b0, operand}; m_acc_en = 1'b1; end
          SUB:  begin m_result = acc_in - operand; m_carry = (acc_in >= operand); m_acc_en = 1'b1; end
          NAND: begin m_result = ~(acc_in & operand); m_carry = 1'b0; m_acc_en = 1'b1; end
          CMP:  m_carry = (acc_in >= operand);
          MUL:  begin mul_prod = {4'b0, acc_in} * {4'b0, operand}; mul_left = W; end
          ADC:  begin {m_carry, m_result} = {1'b0, acc_in} + {1'b0, operand} + {4'b0, m_carry}; m_acc_en = 1'b1; end
          default: ;
        endcase
        if (op == CMP) m_zero = (acc_in == operand);
        else if (m_acc_en) m_zero = (m_result == 0);
      end
      if (m_acc_en) acc_q <= m_result;
    end
    m_busy = (mul_left > 0);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_result", result, m_result);
      check("cyc_acc_en", acc_en, m_acc_en);
      check("cyc_busy",   busy,   m_busy);
      check("cyc_carry",  carry,  m_carry);
      check("cyc_zero",   zero,   m_zero);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; acc_drv = a; operand = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_not_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic c,
                            input logic z, input logic e);
    check({tag, "_result"}, result, r);
    check({tag, "_carry"},  carry,  c);
    check({tag, "_zero"},   zero,   z);
    check({tag, "_acc_en"}, acc_en, e);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b1; op = ADD; acc_drv = 4'hA; operand = 4'h7; use_acc = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cmp_en = 1'b1;
      expect_out("rst", 4'h0, 1'b0, 1'b0, 1'b0);
      check("rst_busy", busy, 1'b0);
    end
    reset = 1'b1; start = 1'b0;

    issue(ADD, 4'hA, 4'h7);
    expect_out("add", 4'h1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("add_pulse_end", acc_en, 1'b0);
    issue(ADC, 4'h1, 4'h0);
    expect_out("adc", 4'h2, 1'b0, 1'b0, 1'b1);

    issue(SUB, 4'h5, 4'h5);
    expect_out("sub_eq", 4'h0, 1'b1, 1'b1, 1'b1);
    issue(SUB, 4'h3, 4'h5);
    expect_out("sub_borrow", 4'hE, 1'b0, 1'b0, 1'b1);
    issue(CMP, 4'h2, 4'h9);
    expect_out("cmp", 4'hE, 1'b0, 1'b0, 1'b0);
    issue(NOP, 4'h7, 4'h7);
    expect_out("nop", 4'hE, 1'b0, 1'b0, 1'b0);

    issue(MUL, 4'h3, 4'h5);
    wait_not_busy(n);
    check("mul35_busy_cycles", n, 4);
    expect_out("mul35", 4'hF, 1'b0, 1'b0, 1'b1);

    issue(MUL, 4'hF, 4'hF);
    wait_not_busy(n);
    check("mulff_busy_cycles", n, 4);
    expect_out("mulff", 4'h1, 1'b1, 1'b0, 1'b1);

    issue(MUL, 4'hF, 4'hF);
    start = 1'b1; op = ADD; acc_drv = 4'h1; operand = 4'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_not_busy(n);
    expect_out("mul_ignore_add", 4'h1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("mul_ignore_hold", result, 4'h1);

    issue(MUL, 4'h3, 4'h5);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    expect_out("abort", 4'h0, 1'b0, 1'b0, 1'b0);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_en", acc_en, 1'b0);
    end
    issue(ADD, 4'h1, 4'h1);
    expect_out("post_abort_add", 4'h2, 1'b0, 1'b0, 1'b1);

    use_acc = 1'b1;
    start = 1'b1; op = PASS; operand = 4'h6;
    @(posedge clk); #1;
    check("b2b_pass", result, 4'h6); check("b2b_pass_en", acc_en, 1'b1);
    op = ADD;
    @(posedge clk); #1;
    check("b2b_add", result, 4'hC); check("b2b_add_en", acc_en, 1'b1);
    op = SUB;
    @(posedge clk); #1;
    check("b2b_sub", result, 4'h6); check("b2b_sub_en", acc_en, 1'b1);
    start = 1'b0;

    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) use_acc = $urandom_range(0, 1) != 0;
      reset   = ($urandom_range(0, 59) != 0);
      start   = $urandom_range(0, 1) != 0;
      op      = 3'($urandom_range(0, 7));
      acc_drv = W'($urandom);
      operand = W'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b1; start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the nibble processor, directly upstream of the accumulator register.
- Combines the current accumulator value (acc_in) with a bus operand and produces a registered result plus a one-cycle acc_en pulse.
- Wire result to the accumulator D input and acc_en to its enable input.
- Holds the carry and zero flags; MUL is a multi-cycle shift-add operation with a busy handshake.

Parameters:
- WIDTH, 4, datapath width in bits; MUL iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request to execute op; accepted only when busy=0
- op  input  3  operation code
- acc_in  input  WIDTH  operand A, the accumulator Q
- operand  input  WIDTH  operand B, from the data bus
- result  output  WIDTH  registered result, drives accumulator D
- acc_en  output  1  one-cycle pulse, drives accumulator enable
- busy  output  1  high while a MUL is in progress
- carry  output  1  registered carry/no-borrow/overflow flag
- zero  output  1  registered zero flag

Behaviour:
- Reset: clk edge with reset=0 forces result=0, acc_en=0, busy=0, carry=0, zero=0 and state=IDLE. This overrides start and aborts any MUL in progress; no acc_en is issued for an aborted MUL.
- Accept: start=1 and busy=0 at a rising edge. start while busy=1 is ignored, not queued.
- Opcodes (A=acc_in, B=operand):
  - 000 PASS: result=B, zero updated, carry unchanged.
  - 001 ADD: {carry,result}=A+B.
  - 010 SUB: result=A-B mod 2^WIDTH, carry=1 iff A>=B (no borrow).
  - 011 NAND: result=~(A&B), carry=0.
  - 100 CMP: flags as SUB, result unchanged, no acc_en.
  - 101 MUL: multi-cycle, see below.
  - 110 ADC: {carry,result}=A+B+carry (old carry value).
  - 111 NOP: nothing changes, no acc_en.
- zero=1 iff the new result==0. For CMP, zero reflects A-B.
- Single-cycle ops, latency 1: accepted at edge N -> result, flags and acc_en=1 are registered at edge N. The accumulator captures at edge N+1, and acc_en returns to 0 at edge N+1 unless another op is accepted at that edge.
- start held high gives back-to-back single-cycle ops, one per cycle, each operating on acc_in as presented.
- MUL state machine, states IDLE and MUL:
  - Accepted at edge N: latch A and B, clear the 2*WIDTH product register and counter, set busy=1, go to MUL.
  - Each edge in MUL performs one shift-add step.
  - The WIDTH-th step lands on edge N+WIDTH. There: result=product low WIDTH bits, carry=1 iff the high WIDTH bits are nonzero, zero from result, acc_en=1, busy=0, back to IDLE.
  - acc_in/operand changes during MUL have no effect.
  - A new op can be accepted at edge N+WIDTH+1 or later.
- acc_en is never high for more than one cycle per accepted op.
- result holds its value between ops.
- Arithmetic is unsigned; all wrap is modulo 2^WIDTH.

Decomposition:
- Package alu_exec_pkg holds:
  - opcode constants OP_PASS, OP_ADD, OP_SUB, OP_NAND, OP_CMP, OP_MUL, OP_ADC, OP_NOP;
  - state encoding ST_IDLE, ST_MUL;
  - default WIDTH.
- One sub-module, mul_shift_add: WIDTH-cycle unsigned shift-add multiplier with load/step/done. The parent owns flags and acc_en.

Test Plan:
- Reset: reset=0 for 3 edges with start=1, op=ADD, acc_in=4'hA, operand=4'h7 -> result=0, acc_en=0, busy=0, carry=0, zero=0 on every edge.
- ADD/ADC: ADD A=4'hA, B=4'h7 -> next cycle result=4'h1, carry=1, zero=0, acc_en=1 for exactly one cycle. Then ADC A=4'h1, B=4'h0 -> result=4'h2, carry=0.
- SUB/CMP/NOP:
  - SUB 4'h5-4'h5 -> result=0, zero=1, carry=1.
  - SUB 4'h3-4'h5 -> result=4'hE, carry=0.
  - CMP 4'h2 vs 4'h9 -> carry=0, zero=0, result unchanged, acc_en stays 0.
  - NOP -> all outputs hold.
- MUL:
  - 4'h3*4'h5 -> busy=1 for 4 cycles, then result=4'hF, carry=0, acc_en pulse.
  - 4'hF*4'hF -> result=4'h1, carry=1.
  - start=1 with op=ADD during busy -> ignored; result still 4'h1.
- Reset mid-MUL: assert reset=0 on the 2nd busy cycle of 4'h3*4'h5 -> busy=0, result=0, no acc_en pulse ever. A following ADD 4'h1+4'h1 gives result=4'h2 after one cycle.
- Back-to-back: start held high with ops PASS 4'h6, ADD, SUB on consecutive cycles, acc_in fed from a model accumulator -> one acc_en per cycle, results 4'h6, 4'hC, 4'h6 for B=4'h6.
